sandbox_alu_process: RTL and testbench

Parametrised successor of the sandbox demo process. It keeps the same dataReceived/clearDR/transmitData host handshake and adds an opcode-selected datapath with a persistent accumulator and a transaction counter. It also adds configurable handshake timing, a release-timeout error flag and a stretchable rxIndicator pulse. It sits inside the sandbox between the host receive/transmit framing logic and the user LEDs.

---
 rtl/sandbox_pkg.sv | 34 +++
 rtl/sandbox_alu_process_if.sv | 24 ++
 rtl/sandbox_indicator.sv | 87 ++++++++
 rtl/sandbox_alu_process.sv | 198 +++++++++++++++++++
 tb/tb_sandbox_alu_process.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sandbox_pkg.sv
// Shared opcodes, FSM encodings and constants for the sandbox ALU process.
package sandbox_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned PULSE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_ECHO  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_CLR   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_BSWAP = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_INV   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_COUNT = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_READ  = 4'd7;

  // Undefined opcodes return this bit replicated across the whole result word.
  localparam logic ERR_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } aluStateT;

  typedef enum logic [1:0] {
    IND_IDLE      = 2'd0,
    IND_WAIT_RISE = 2'd1,
    IND_WAIT_FALL = 2'd2,
    IND_ACTIVE    = 2'd3
  } indStateT;

endpackage

// File: rtl/sandbox_alu_process_if.sv
// Host handshake bus between the framing logic (master) and the ALU process (slave).
interface sandbox_alu_process_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
);

  logic              dataReceived;
  logic [CTRL_W-1:0] control;
  logic [DATA_W-1:0] inputData;
  logic              clearDR;
  logic              transmitData;
  logic [DATA_W-1:0] outputData;

  modport master (
    output dataReceived, control, inputData,
    input  clearDR, transmitData, outputData
  );

  modport slave (
    input  dataReceived, control, inputData,
    output clearDR, transmitData, outputData
  );

endinterface

// File: rtl/sandbox_indicator.sv
// LED pulse generator: synchronises slowClock and stretches a trigger into
// IND_PULSES slowClock periods, ignoring triggers while a pulse is in flight.
module sandbox_indicator
  import sandbox_pkg::*;
#(
  parameter int unsigned IND_PULSES = 1
) (
  input  logic masterClock,
  input  logic reset,
  input  logic slowClock,
  input  logic trigger,
  output logic rxIndicator
);

  if (IND_PULSES < 1 || IND_PULSES > 15) begin : gBadPulses
    $error("IND_PULSES must be in 1..15");
  end

  logic slowMeta, slowSync, slowPrev;
  logic slowRise, slowFall;
  indStateT state, nextState;
  logic [PULSE_W-1:0] pulseCnt, pulseNext;
  logic rxNext;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      slowMeta <= 1'b0;
      slowSync <= 1'b0;
      slowPrev <= 1'b0;
    end else begin
      slowMeta <= slowClock;
      slowSync <= slowMeta;
      slowPrev <= slowSync;
    end
  end

  assign slowRise = slowSync & ~slowPrev;
  assign slowFall = ~slowSync & slowPrev;

  always_ff @(posedge masterClock) begin
    if (!reset) state <= IND_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IND_IDLE:      if (trigger)  nextState = IND_WAIT_RISE;
      IND_WAIT_RISE: if (slowRise) nextState = IND_WAIT_FALL;
      IND_WAIT_FALL: if (slowFall) nextState = IND_ACTIVE;
      IND_ACTIVE:    if (slowFall && pulseCnt == PULSE_W'(1)) nextState = IND_IDLE;
      default:       nextState = IND_IDLE;
    endcase
  end

  always_comb begin
    rxNext    = rxIndicator;
    pulseNext = pulseCnt;
    case (state)
      IND_WAIT_FALL: begin
        if (slowFall) begin
          rxNext    = 1'b1;
          pulseNext = PULSE_W'(IND_PULSES);
        end
      end
      IND_ACTIVE: begin
        if (slowFall) begin
          if (pulseCnt == PULSE_W'(1)) rxNext = 1'b0;
          else                         pulseNext = pulseCnt - PULSE_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      rxIndicator <= 1'b0;
      pulseCnt    <= '0;
    end else begin
      rxIndicator <= rxNext;
      pulseCnt    <= pulseNext;
    end
  end

endmodule

// File: rtl/sandbox_alu_process.sv
// Sandbox ALU process: host handshake around an opcode-selected datapath with
// a persistent accumulator, transaction counter, release timeout and LED pulse.
module sandbox_alu_process
  import sandbox_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned CTRL_W          = 8,
  parameter int unsigned TX_HOLD         = 1,
  parameter int unsigned RELEASE_TIMEOUT = 1024,
  parameter int unsigned IND_PULSES      = 1
) (
  input  logic                 masterClock,
  input  logic                 reset,
  input  logic                 slowClock,
  sandbox_alu_process_if.slave hostBus,
  output logic                 rxIndicator,
  output logic                 busy,
  output logic                 errorFlag
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TO_W   = (RELEASE_TIMEOUT < 2) ? 1 : $clog2(RELEASE_TIMEOUT + 1);

  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : gBadDataW
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (CTRL_W < OPCODE_W) begin : gBadCtrlW
    $error("CTRL_W must be at least 4");
  end
  if (TX_HOLD > 255) begin : gBadTxHold
    $error("TX_HOLD must be in 0..255");
  end

  // Control bits above the opcode are deliberately ignored.
  if (CTRL_W > OPCODE_W) begin : gCtrlHigh
    logic unusedCtrl;
    assign unusedCtrl = ^hostBus.control[CTRL_W-1:OPCODE_W];
  end

  aluStateT state, nextState;

  logic [OPCODE_W-1:0] opLatch, opNext;
  logic [DATA_W-1:0]   dataLatch, dataNext;
  logic [DATA_W-1:0]   acc, accNext;
  logic [DATA_W-1:0]   count, countNext;
  logic [DATA_W-1:0]   outNext;
  logic [HOLD_W-1:0]   holdCnt, holdNext;
  logic [TO_W-1:0]     toCnt, toNext;
  logic                txNext, clrNext, errNext, busyNext;

  logic [DATA_W-1:0]   swapped, execResult, execAcc;
  logic                execSetErr, execClrErr;
  logic                toEnabled, toLast;

  always_ff @(posedge masterClock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:    if (hostBus.dataReceived) nextState = ST_EXEC;
      ST_EXEC:    nextState = ST_HOLD;
      ST_HOLD:    if (holdCnt == '0) nextState = ST_DONE;
      ST_DONE:    nextState = ST_RELEASE;
      ST_RELEASE: if (!hostBus.dataReceived) nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
  end

  // Opcode datapath on the latched operand.
  always_comb begin
    swapped = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      swapped[i*8 +: 8] = dataLatch[(BYTES-1-i)*8 +: 8];
    end
    execResult = dataLatch;
    execAcc    = acc;
    execSetErr = 1'b0;
    execClrErr = 1'b0;
    case (opLatch)
      OP_ECHO:  execResult = dataLatch;
      OP_ADD: begin
        execAcc    = acc + dataLatch;
        execResult = execAcc;
      end
      OP_XOR: begin
        execAcc    = acc ^ dataLatch;
        execResult = execAcc;
      end
      OP_CLR: begin
        execAcc    = '0;
        execResult = '0;
        execClrErr = 1'b1;
      end
      OP_BSWAP: execResult = swapped;
      OP_INV:   execResult = ~dataLatch;
      OP_COUNT: execResult = count + DATA_W'(1);
      OP_READ:  execResult = acc;
      default: begin
        execResult = {DATA_W{ERR_FILL}};
        execSetErr = 1'b1;
      end
    endcase
  end

  assign toEnabled = (RELEASE_TIMEOUT != 0) && (toCnt != TO_W'(RELEASE_TIMEOUT));
  assign toLast    = (toCnt == TO_W'(RELEASE_TIMEOUT - 1));

  // Next values of every registered output and datapath register.
  always_comb begin
    opNext    = opLatch;
    dataNext  = dataLatch;
    accNext   = acc;
    countNext = count;
    outNext   = hostBus.outputData;
    txNext    = hostBus.transmitData;
    clrNext   = hostBus.clearDR;
    errNext   = errorFlag;
    holdNext  = holdCnt;
    toNext    = toCnt;
    busyNext  = (nextState != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (hostBus.dataReceived) begin
          opNext   = hostBus.control[OPCODE_W-1:0];
          dataNext = hostBus.inputData;
        end
      end
      ST_EXEC: begin
        outNext   = execResult;
        txNext    = 1'b1;
        accNext   = execAcc;
        countNext = count + DATA_W'(1);
        holdNext  = HOLD_W'(TX_HOLD);
        if (execSetErr) errNext = 1'b1;
        if (execClrErr) errNext = 1'b0;
      end
      ST_HOLD: begin
        // clearDR rises on the edge that leaves HOLD.
        if (holdCnt == '0) clrNext = 1'b1;
        else               holdNext = holdCnt - HOLD_W'(1);
      end
      ST_DONE: toNext = '0;
      ST_RELEASE: begin
        if (!hostBus.dataReceived) begin
          txNext  = 1'b0;
          clrNext = 1'b0;
        end else if (toEnabled) begin
          toNext = toCnt + TO_W'(1);
          if (toLast) errNext = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      opLatch              <= '0;
      dataLatch            <= '0;
      acc                  <= '0;
      count                <= '0;
      hostBus.outputData   <= '0;
      hostBus.transmitData <= 1'b0;
      hostBus.clearDR      <= 1'b0;
      errorFlag            <= 1'b0;
      holdCnt              <= '0;
      toCnt                <= '0;
      busy                 <= 1'b0;
    end else begin
      opLatch              <= opNext;
      dataLatch            <= dataNext;
      acc                  <= accNext;
      count                <= countNext;
      hostBus.outputData   <= outNext;
      hostBus.transmitData <= txNext;
      hostBus.clearDR      <= clrNext;
      errorFlag            <= errNext;
      holdCnt              <= holdNext;
      toCnt                <= toNext;
      busy                 <= busyNext;
    end
  end

  sandbox_indicator #(
    .IND_PULSES (IND_PULSES)
  ) uIndicator (
    .masterClock (masterClock),
    .reset       (reset),
    .slowClock   (slowClock),
    .trigger     (state == ST_EXEC),
    .rxIndicator (rxIndicator)
  );

endmodule

// File: tb/tb_sandbox_alu_process.sv
// Directed bench for sandbox_alu_process: handshake timing, opcodes, timeout,
// reset abort and indicator pulse width.
module tb_sandbox_alu_process;

  logic masterClock;
  logic reset;
  logic slowClock;
  logic rxIndicator;
  logic busy;
  logic errorFlag;

  int compared   = 0;
  int mismatched = 0;

  sandbox_alu_process_if #(.DATA_W(32), .CTRL_W(8)) bus ();

  sandbox_alu_process #(
    .DATA_W          (32),
    .CTRL_W          (8),
    .TX_HOLD         (1),
    .RELEASE_TIMEOUT (16),
    .IND_PULSES      (2)
  ) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .slowClock   (slowClock),
    .hostBus     (bus.slave),
    .rxIndicator (rxIndicator),
    .busy        (busy),
    .errorFlag   (errorFlag)
  );

  initial begin
    masterClock = 1'b0;
    forever #5 masterClock = ~masterClock;
  end

  // 8-cycle slowClock period, offset so its edges never coincide with masterClock.
  initial begin
    slowClock = 1'b0;
    #3;
    forever #40 slowClock = ~slowClock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic doReset();
    @(negedge masterClock);
    reset = 1'b0;
    bus.dataReceived = 1'b0;
    tick();
    tick();
    @(negedge masterClock);
    reset = 1'b1;
  endtask

  task automatic runTxn(input logic [7:0] ctrl, input logic [31:0] data, output logic [31:0] result);
    int n;
    @(negedge masterClock);
    bus.control      = ctrl;
    bus.inputData    = data;
    bus.dataReceived = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.transmitData && n < 20);
    compared++;
    if (!bus.transmitData) begin
      mismatched++;
      $display("FAIL txn_tx_wait ctrl=%h: transmitData=%b required 1", ctrl, bus.transmitData);
    end
    result = bus.outputData;
    n = 0;
    while (!bus.clearDR && n < 20) begin tick(); n++; end
    compared++;
    if (!bus.clearDR) begin
      mismatched++;
      $display("FAIL txn_clr_wait ctrl=%h: clearDR=%b required 1", ctrl, bus.clearDR);
    end
    bus.dataReceived = 1'b0;
    n = 0;
    while ((busy || bus.transmitData || bus.clearDR) && n < 20) begin tick(); n++; end
    compared++;
    if (busy || bus.transmitData || bus.clearDR) begin
      mismatched++;
      $display("FAIL txn_release ctrl=%h: busy=%b tx=%b clr=%b required 0 0 0",
               ctrl, busy, bus.transmitData, bus.clearDR);
    end
  endtask

  task automatic test_reset();
    doReset();
    compared++;
    if (bus.outputData !== 32'h0 || bus.transmitData !== 1'b0 || bus.clearDR !== 1'b0 ||
        rxIndicator !== 1'b0 || busy !== 1'b0 || errorFlag !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: out=%h tx=%b clr=%b ind=%b busy=%b err=%b required all 0",
               bus.outputData, bus.transmitData, bus.clearDR, rxIndicator, busy, errorFlag);
    end
  endtask

  task automatic test_echo_timing();
    @(negedge masterClock);
    bus.control = 8'h00; bus.inputData = 32'h12345678; bus.dataReceived = 1'b1;
    tick(); // edge k
    compared++;
    if (bus.transmitData !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL echo_k: tx=%b busy=%b required 0 1", bus.transmitData, busy);
    end
    tick(); // edge k+1
    compared++;
    if (bus.transmitData !== 1'b1 || bus.outputData !== 32'h12345678 || bus.clearDR !== 1'b0) begin
      mismatched++;
      $display("FAIL echo_k1: tx=%b out=%h clr=%b required 1 12345678 0",
               bus.transmitData, bus.outputData, bus.clearDR);
    end
    tick(); // edge k+2
    compared++;
    if (bus.clearDR !== 1'b0) begin
      mismatched++;
      $display("FAIL echo_k2_clr: clearDR=%b required 0", bus.clearDR);
    end
    tick(); // edge k+3
    compared++;
    if (bus.clearDR !== 1'b1 || bus.transmitData !== 1'b1) begin
      mismatched++;
      $display("FAIL echo_k3_clr: clearDR=%b tx=%b required 1 1", bus.clearDR, bus.transmitData);
    end
    tick(); // edge k+4, now in RELEASE
    bus.dataReceived = 1'b0;
    tick();
    compared++;
    if (bus.transmitData !== 1'b0 || bus.clearDR !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL echo_release: tx=%b clr=%b busy=%b required 0 0 0",
               bus.transmitData, bus.clearDR, busy);
    end
  endtask

  task automatic test_add_count();
    logic [31:0] r;
    doReset();
    runTxn(8'h01, 32'h00000005, r);
    compared++;
    if (r !== 32'h00000005) begin mismatched++; $display("FAIL add_first: got %h required 00000005", r); end
    runTxn(8'h01, 32'hFFFFFFFE, r);
    compared++;
    if (r !== 32'h00000003) begin mismatched++; $display("FAIL add_wrap: got %h required 00000003", r); end
    runTxn(8'h06, 32'hDEADBEEF, r);
    compared++;
    if (r !== 32'h00000003) begin mismatched++; $display("FAIL count: got %h required 00000003", r); end
    runTxn(8'h07, 32'h0, r);
    compared++;
    if (r !== 32'h00000003) begin mismatched++; $display("FAIL read: got %h required 00000003", r); end
  endtask

  task automatic test_logic_ops();
    logic [31:0] r;
    runTxn(8'h04, 32'h11223344, r);
    compared++;
    if (r !== 32'h44332211) begin mismatched++; $display("FAIL bswap: got %h required 44332211", r); end
    runTxn(8'h05, 32'h0000FFFF, r);
    compared++;
    if (r !== 32'hFFFF0000) begin mismatched++; $display("FAIL inv: got %h required FFFF0000", r); end
    runTxn(8'h03, 32'h12345678, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL clr: got %h required 00000000", r); end
    runTxn(8'h02, 32'hA5A5A5A5, r);
    compared++;
    if (r !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL xor: got %h required A5A5A5A5", r); end
    runTxn(8'h02, 32'h0F0F0F0F, r);
    compared++;
    if (r !== 32'hAAAAAAAA) begin mismatched++; $display("FAIL xor2: got %h required AAAAAAAA", r); end
  endtask

  task automatic test_error_opcode();
    logic [31:0] r;
    runTxn(8'h0F, 32'h01020304, r);
    compared++;
    if (r !== 32'hFFFFFFFF || errorFlag !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_opcode: out=%h err=%b required FFFFFFFF 1", r, errorFlag);
    end
    runTxn(8'h97, 32'h0, r);
    compared++;
    if (r !== 32'hAAAAAAAA || errorFlag !== 1'b1) begin
      mismatched++;
      $display("FAIL high_bits_read: out=%h err=%b required AAAAAAAA 1", r, errorFlag);
    end
    runTxn(8'hF3, 32'h55555555, r);
    compared++;
    if (r !== 32'h0 || errorFlag !== 1'b0) begin
      mismatched++;
      $display("FAIL masked_clr: out=%h err=%b required 00000000 0", r, errorFlag);
    end
  endtask

  task automatic test_release_timeout();
    logic [31:0] r;
    int n;
    @(negedge masterClock);
    bus.control = 8'h00; bus.inputData = 32'hCAFEF00D; bus.dataReceived = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.clearDR && n < 20);
    compared++;
    if (!bus.clearDR) begin mismatched++; $display("FAIL timeout_clr_wait: clearDR=%b required 1", bus.clearDR); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 16) begin
        compared++;
        if (errorFlag !== 1'b0) begin mismatched++; $display("FAIL timeout_early: err=%b required 0", errorFlag); end
      end
      if (i == 17) begin
        compared++;
        if (errorFlag !== 1'b1) begin mismatched++; $display("FAIL timeout_set: err=%b required 1", errorFlag); end
      end
    end
    compared++;
    if (busy !== 1'b1 || bus.clearDR !== 1'b1 || bus.transmitData !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_stay: busy=%b clr=%b tx=%b required 1 1 1", busy, bus.clearDR, bus.transmitData);
    end
    bus.dataReceived = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || bus.transmitData !== 1'b0 || errorFlag !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_exit: busy=%b tx=%b err=%b required 0 0 1", busy, bus.transmitData, errorFlag);
    end
    runTxn(8'h03, 32'h0, r);
    compared++;
    if (errorFlag !== 1'b0) begin mismatched++; $display("FAIL timeout_clr_err: err=%b required 0", errorFlag); end
  endtask

  task automatic test_reset_in_hold();
    logic [31:0] r;
    doReset();
    runTxn(8'h01, 32'h00000007, r);
    @(negedge masterClock);
    bus.control = 8'h01; bus.inputData = 32'h00000001; bus.dataReceived = 1'b1;
    tick();
    tick(); // transmitData high, FSM in HOLD
    compared++;
    if (bus.transmitData !== 1'b1) begin mismatched++; $display("FAIL hold_pre: tx=%b required 1", bus.transmitData); end
    @(negedge masterClock);
    reset = 1'b0;
    bus.dataReceived = 1'b0;
    tick();
    compared++;
    if (bus.outputData !== 32'h0 || bus.transmitData !== 1'b0 || bus.clearDR !== 1'b0 ||
        busy !== 1'b0 || errorFlag !== 1'b0 || rxIndicator !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_abort: out=%h tx=%b clr=%b busy=%b err=%b ind=%b required all 0",
               bus.outputData, bus.transmitData, bus.clearDR, busy, errorFlag, rxIndicator);
    end
    @(negedge masterClock);
    reset = 1'b1;
    runTxn(8'h07, 32'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL hold_acc: got %h required 00000000", r); end
    runTxn(8'h06, 32'h0, r);
    compared++;
    if (r !== 32'h00000002) begin mismatched++; $display("FAIL hold_count: got %h required 00000002", r); end
  endtask

  task automatic test_indicator();
    logic [31:0] r;
    int n;
    int width;
    bit reRise;
    doReset();
    runTxn(8'h00, 32'h1, r);
    n = 0;
    while (!rxIndicator && n < 60) begin tick(); n++; end
    compared++;
    if (!rxIndicator) begin mismatched++; $display("FAIL ind_rise: rxIndicator=%b required 1", rxIndicator); end
    width = 1;
    fork
      begin
        n = 0;
        while (n < 100) begin
          tick();
          n++;
          if (rxIndicator) width++;
          else break;
        end
      end
      runTxn(8'h00, 32'h2, r);
    join
    compared++;
    if (width !== 16) begin mismatched++; $display("FAIL ind_width: %0d cycles required 16", width); end
    reRise = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rxIndicator) reRise = 1'b1;
    end
    compared++;
    if (reRise) begin mismatched++; $display("FAIL ind_dropped: rxIndicator rose again, required 0"); end
  endtask

  initial begin
    reset            = 1'b0;
    bus.dataReceived = 1'b0;
    bus.control      = '0;
    bus.inputData    = '0;
    test_reset();
    test_echo_timing();
    test_add_count();
    test_logic_ops();
    test_error_opcode();
    test_release_timeout();
    test_reset_in_hold();
    test_indicator();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
